// File: rtl/gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : gsensor_spi_responder
// Brief    : SPI mode-3 slave emulating an accelerometer register map
//            (64 x 8 registers, DEVID at 0x00) with a local write port.
// Revision : 1.0 - initial release
// ============================================================================
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID   = 8'hE5,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       gsensor_SCLK,
    input  logic       gsensor_SS_n,
    input  logic       gsensor_MOSI,
    output logic       gsensor_MISO,
    input  logic       reg_wr_en,
    input  logic [5:0] reg_wr_addr,
    input  logic [7:0] reg_wr_data,
    output logic       spi_wr_valid,
    output logic [5:0] spi_wr_addr,
    output logic [7:0] spi_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [2:0] c_last_bit = 3'd7;

    state_t     r_state;
    logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic       r_ss_s1, r_ss_s2, r_ss_d;
    logic       r_mosi_s1, r_mosi_s2;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [6:0] r_tx_shift;
    logic [5:0] r_addr;
    logic       r_rw;
    logic       r_mb;
    logic [7:0] r_regs [0:63];

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_ss_fall;
    logic [7:0] w_rx_byte;
    logic       w_spi_we;
    logic [7:0] w_rd_data;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sclk_s1 <= 1'b1;
            r_sclk_s2 <= 1'b1;
            r_sclk_d  <= 1'b1;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sclk_s1 <= gsensor_SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_ss_s1   <= gsensor_SS_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_d    <= r_ss_s2;
            r_mosi_s1 <= gsensor_MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_ss_fall   = ~r_ss_s2 & r_ss_d;
    assign w_rx_byte   = {r_rx_shift, r_mosi_s2};
    assign w_spi_we    = (r_state == DATA) && !r_ss_s2 && !r_rw &&
                         w_sclk_rise && (r_bit_cnt == c_last_bit);
    assign w_rd_data   = (r_addr == 6'd0) ? DEVID : r_regs[r_addr];

    // Entry 0 is never written and never read; DEVID is muxed in instead.
    // The SPI write is applied last so it wins an address collision.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < 64; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else begin
            if (reg_wr_en && (reg_wr_addr != 6'd0)) begin
                r_regs[reg_wr_addr] <= reg_wr_data;
            end
            if (w_spi_we && (r_addr != 6'd0)) begin
                r_regs[r_addr] <= w_rx_byte;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_rx_shift   <= 7'd0;
            r_tx_shift   <= 7'd0;
            r_addr       <= 6'd0;
            r_rw         <= 1'b0;
            r_mb         <= 1'b0;
            gsensor_MISO <= 1'b1;
            spi_wr_valid <= 1'b0;
            spi_wr_addr  <= 6'd0;
            spi_wr_data  <= 8'd0;
        end else begin
            spi_wr_valid <= w_spi_we;
            if (w_spi_we) begin
                spi_wr_addr <= r_addr;
                spi_wr_data <= w_rx_byte;
            end

            if (r_ss_s2) begin
                r_state      <= IDLE;
                r_bit_cnt    <= 3'd0;
                gsensor_MISO <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ss_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        gsensor_MISO <= 1'b1;
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_rw    <= w_rx_byte[7];
                                r_mb    <= w_rx_byte[6];
                                r_addr  <= w_rx_byte[5:0];
                                r_state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= w_rx_byte[6:0];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if ((r_bit_cnt == c_last_bit) && r_mb) begin
                                r_addr <= r_addr + 6'd1;
                            end
                        end
                        // Read data is snapshotted at the first fall of each byte.
                        if (w_sclk_fall) begin
                            if (!r_rw) begin
                                gsensor_MISO <= 1'b1;
                            end else if (r_bit_cnt == 3'd0) begin
                                r_tx_shift   <= w_rd_data[6:0];
                                gsensor_MISO <= w_rd_data[7];
                            end else begin
                                r_tx_shift   <= {r_tx_shift[5:0], 1'b0};
                                gsensor_MISO <= r_tx_shift[6];
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsensor_spi_responder
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized transactions against a register-map reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_spi_responder;

    localparam logic [7:0] DEVID   = 8'hE5;
    localparam logic [7:0] RST_VAL = 8'h00;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       gsensor_SCLK;
    logic       gsensor_SS_n;
    logic       gsensor_MOSI;
    logic       gsensor_MISO;
    logic       reg_wr_en;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       spi_wr_valid;
    logic [5:0] spi_wr_addr;
    logic [7:0] spi_wr_data;

    gsensor_spi_responder #(.DEVID(DEVID), .RST_VAL(RST_VAL)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .gsensor_SCLK (gsensor_SCLK),
        .gsensor_SS_n (gsensor_SS_n),
        .gsensor_MOSI (gsensor_MOSI),
        .gsensor_MISO (gsensor_MISO),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data)
    );

    always #5 clk_clk = ~clk_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_regs [0:63];
    logic [7:0]  tx_buf [0:7];
    logic [7:0]  rx_buf [0:7];
    logic [7:0]  rx_cmd;
    logic [7:0]  exp_rx [0:7];
    logic [13:0] exp_wr_q [$];
    logic [13:0] wr_q [$];

    // Every high cycle of the strobe is logged, so a stretched pulse shows up.
    always @(negedge clk_clk) begin
        if (spi_wr_valid === 1'b1) wr_q.push_back({spi_wr_addr, spi_wr_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk_clk);
    endtask

    function automatic logic [7:0] m_rd(input logic [5:0] a);
        return (a == 6'd0) ? DEVID : m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = RST_VAL;
    endtask

    // Reference: a transaction is a command byte followed by n data bytes.
    task automatic model_txn(input logic [7:0] cmd, input int n);
        logic [5:0] a;
        a = cmd[5:0];
        exp_wr_q.delete();
        for (int b = 0; b < n; b++) begin
            if (cmd[7]) begin
                exp_rx[b] = m_rd(a);
            end else begin
                exp_rx[b] = 8'hFF;
                if (a != 6'd0) m_regs[a] = tx_buf[b];
                exp_wr_q.push_back({a, tx_buf[b]});
            end
            if (cmd[6]) a = a + 6'd1;
        end
    endtask

    task automatic local_wr(input logic [5:0] a, input logic [7:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = a;
        reg_wr_data = d;
        wait_n(1);
        reg_wr_en   = 1'b0;
        if (a != 6'd0) m_regs[a] = d;
    endtask

    // One SCLK period; optional local write aimed at the cycle the DUT acts on this rise.
    task automatic spi_bit(input logic v, output logic r, input bit coll,
                           input logic [5:0] ca, input logic [7:0] cd);
        gsensor_SCLK = 1'b0;
        gsensor_MOSI = v;
        wait_n(6);
        r = gsensor_MISO;
        gsensor_SCLK = 1'b1;
        if (coll) begin
            wait_n(2);
            reg_wr_en   = 1'b1;
            reg_wr_addr = ca;
            reg_wr_data = cd;
            wait_n(1);
            reg_wr_en   = 1'b0;
            wait_n(3);
        end else begin
            wait_n(6);
        end
    endtask

    task automatic spi_byte(input logic [7:0] v, output logic [7:0] r, input bit coll,
                            input logic [5:0] ca, input logic [7:0] cd);
        logic bit_r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(v[i], bit_r, coll && (i == 0), ca, cd);
            r[i] = bit_r;
        end
    endtask

    task automatic do_txn(input logic [7:0] cmd, input int n, input bit coll,
                          input logic [5:0] ca, input logic [7:0] cd);
        wr_q.delete();
        gsensor_SS_n = 1'b0;
        wait_n(6);
        spi_byte(cmd, rx_cmd, 1'b0, 6'd0, 8'd0);
        for (int b = 0; b < n; b++) spi_byte(tx_buf[b], rx_buf[b], coll && (b == 0), ca, cd);
        wait_n(6);
        gsensor_SS_n = 1'b1;
        wait_n(10);
    endtask

    task automatic check_vs_model(input string tag, input int n);
        check({tag, " cmd MISO"}, {24'd0, rx_cmd}, 32'hFF);
        for (int b = 0; b < n; b++) check({tag, " data"}, {24'd0, rx_buf[b]}, {24'd0, exp_rx[b]});
        check({tag, " wr count"}, wr_q.size(), exp_wr_q.size());
        for (int k = 0; k < wr_q.size() && k < exp_wr_q.size(); k++)
            check({tag, " wr addr/data"}, {18'd0, wr_q[k]}, {18'd0, exp_wr_q[k]});
    endtask

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [47:0] tx;
        logic [47:0] exp;
        int          nwr;
        logic [13:0] wr;
    } vec_t;

    vec_t vt [0:5];

    initial begin
        logic bit_r;

        vt[0] = '{8'h80, 1, 48'h0,            48'hE5_0000000000, 0, 14'h0};
        vt[1] = '{8'h31, 1, 48'h0B_0000000000, 48'hFF_0000000000, 1, {6'h31, 8'h0B}};
        vt[2] = '{8'hB1, 1, 48'h0,            48'h0B_0000000000, 0, 14'h0};
        vt[3] = '{8'hF2, 6, 48'h0,            48'h112233445566,  0, 14'h0};
        vt[4] = '{8'hFF, 2, 48'h0,            48'hA5E5_00000000, 0, 14'h0};
        vt[5] = '{8'hBF, 2, 48'h0,            48'hA5A5_00000000, 0, 14'h0};

        reset_reset  = 1'b1;
        gsensor_SCLK = 1'b1;
        gsensor_SS_n = 1'b1;
        gsensor_MOSI = 1'b0;
        reg_wr_en    = 1'b0;
        reg_wr_addr  = 6'd0;
        reg_wr_data  = 8'd0;
        model_reset();
        wait_n(3);
        check("reset MISO", {31'd0, gsensor_MISO}, 32'd1);
        check("reset spi_wr_valid", {31'd0, spi_wr_valid}, 32'd0);
        check("reset spi_wr_addr", {26'd0, spi_wr_addr}, 32'd0);
        check("reset spi_wr_data", {24'd0, spi_wr_data}, 32'd0);
        reset_reset = 1'b0;
        wait_n(5);

        // Partial write byte aborted by SS_n: nothing may change.
        gsensor_SS_n = 1'b0;
        wait_n(6);
        wr_q.delete();
        spi_byte(8'h05, rx_cmd, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, bit_r, 1'b0, 6'd0, 8'd0);
        gsensor_SS_n = 1'b1;
        wait_n(10);
        check("abort no wr", wr_q.size(), 0);
        exp_rx[0] = m_rd(6'h05);
        do_txn(8'h85, 1, 1'b0, 6'd0, 8'd0);
        check("abort reg unchanged", {24'd0, rx_buf[0]}, {24'd0, exp_rx[0]});

        for (int i = 0; i < 6; i++) local_wr(6'h32 + 6'(i), 8'h11 * 8'(i + 1));
        local_wr(6'h3F, 8'hA5);

        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < 6; b++) tx_buf[b] = vt[i].tx[47 - 8*b -: 8];
            model_txn(vt[i].cmd, vt[i].n);
            do_txn(vt[i].cmd, vt[i].n, 1'b0, 6'd0, 8'd0);
            check("vec cmd MISO", {24'd0, rx_cmd}, 32'hFF);
            for (int b = 0; b < vt[i].n; b++)
                check($sformatf("vec%0d byte%0d", i, b), {24'd0, rx_buf[b]},
                      {24'd0, vt[i].exp[47 - 8*b -: 8]});
            check($sformatf("vec%0d wr count", i), wr_q.size(), vt[i].nwr);
            if (vt[i].nwr > 0 && wr_q.size() > 0)
                check($sformatf("vec%0d wr addr/data", i), {18'd0, wr_q[0]}, {18'd0, vt[i].wr});
        end

        // Same-cycle collisions: same address (SPI wins), then different addresses.
        tx_buf[0] = 8'h5A;
        local_wr(6'h20, 8'h00);
        m_regs[6'h20] = 8'h3C;
        model_txn(8'h20, 1);
        do_txn(8'h20, 1, 1'b1, 6'h20, 8'h3C);
        check_vs_model("collide same", 1);
        do_txn(8'hA0, 1, 1'b0, 6'd0, 8'd0);
        check("collide same readback", {24'd0, rx_buf[0]}, 32'h5A);
        tx_buf[0] = 8'h77;
        m_regs[6'h22] = 8'h99;
        model_txn(8'h21, 1);
        do_txn(8'h21, 1, 1'b1, 6'h22, 8'h99);
        check_vs_model("collide diff", 1);
        model_txn(8'hE1, 2);
        do_txn(8'hE1, 2, 1'b0, 6'd0, 8'd0);
        check_vs_model("collide diff readback", 2);

        // Reset in the middle of a write data byte.
        wr_q.delete();
        gsensor_SS_n = 1'b0;
        wait_n(6);
        local_wr(6'h10, 8'h44);
        spi_byte(8'h10, rx_cmd, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, bit_r, 1'b0, 6'd0, 8'd0);
        gsensor_SCLK = 1'b0;
        wait_n(2);
        reset_reset = 1'b1;
        #1;
        check("mid-reset MISO", {31'd0, gsensor_MISO}, 32'd1);
        check("mid-reset spi_wr_valid", {31'd0, spi_wr_valid}, 32'd0);
        gsensor_SS_n = 1'b1;
        gsensor_SCLK = 1'b1;
        wait_n(4);
        reset_reset = 1'b0;
        model_reset();
        wait_n(10);
        check("mid-reset no wr", wr_q.size(), 0);
        model_txn(8'h90, 1);
        do_txn(8'h90, 1, 1'b0, 6'd0, 8'd0);
        check_vs_model("post-reset read 0x10", 1);
        tx_buf[0] = 8'h12;
        model_txn(8'h00, 1);
        do_txn(8'h00, 1, 1'b0, 6'd0, 8'd0);
        check_vs_model("write devid", 1);
        model_txn(8'h80, 1);
        do_txn(8'h80, 1, 1'b0, 6'd0, 8'd0);
        check("devid after write", {24'd0, rx_buf[0]}, {24'd0, DEVID});

        for (int it = 0; it < 30; it++) begin
            logic [7:0] cmd;
            int n;
            if ($urandom_range(0, 2) == 0)
                local_wr(6'($urandom_range(0, 63)), 8'($urandom));
            cmd = 8'($urandom);
            n   = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) tx_buf[b] = 8'($urandom);
            model_txn(cmd, n);
            do_txn(cmd, n, 1'b0, 6'd0, 8'd0);
            check_vs_model($sformatf("rand%0d cmd%0h", it, cmd), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
